prm_voxel_feeder: RTL and testbench



---
 rtl/prm_vox_pkg.sv | 20 ++
 rtl/prm_voxel_feeder_if.sv | 26 ++
 rtl/prm_lsb_find.sv | 22 ++
 rtl/prm_voxel_feeder.sv | 132 +++++++++++++
 tb/tb_prm_voxel_feeder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prm_vox_pkg.sv
// Shared constants and state encoding for the PRM voxel feeder.
// A voxel code is {word address, bit index} into the 1024 x 32 occupancy map.
package prm_vox_pkg;

  localparam int VOX_W  = 15;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;
  localparam int BIT_W  = 5;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/prm_voxel_feeder_if.sv
// Occupancy-memory read port plus the voxel/edge-mask link to the checker bank.
// master = feeder side, slave = memory and checker-bank side.
interface prm_voxel_feeder_if
  import prm_vox_pkg::*;
#(
  parameter int NUM_EDGES = 1024
);

  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [WORD_W-1:0]     mem_rd_data;
  logic                  vox_valid;
  logic [VOX_W-1:0]      vox_code;
  logic [NUM_EDGES-1:0]  edge_mask_in;

  modport master (
    output mem_rd_en, mem_addr, vox_valid, vox_code,
    input  mem_rd_data, edge_mask_in
  );

  modport slave (
    input  mem_rd_en, mem_addr, vox_valid, vox_code,
    output mem_rd_data, edge_mask_in
  );

endinterface

// File: rtl/prm_lsb_find.sv
// Combinational lowest-set-bit finder: index of the least significant 1 and
// a found flag that doubles as the non-zero test of the word.
module prm_lsb_find
  import prm_vox_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [BIT_W-1:0]  idx,
  output logic              found
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    idx   = '0;
    found = |word;
    // Walk from the top so the lowest set bit is the last one written.
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (word[i]) idx = BIT_W'(i);
    end
  end

endmodule

// File: rtl/prm_voxel_feeder.sv
// Scans the occupancy bitmap word by word, emits each occupied voxel code to
// the checker bank, and OR-accumulates the returned edge masks into blocked.
module prm_voxel_feeder
  import prm_vox_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int WORD_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_EDGES-1:0] blocked,
  output logic [15:0]          vox_count,
  prm_voxel_feeder_if.master   bus
);

  if (WORD_W != prm_vox_pkg::WORD_W) begin : g_word_w_check
    $error("prm_voxel_feeder: WORD_W must equal prm_vox_pkg::WORD_W");
  end

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  scan_src;
  logic [BIT_W-1:0]   bit_idx;
  logic               found;
  logic               clear_all;
  logic               emit;
  logic               step;
  logic               addr_inc;

  // The working word holds the bits still to emit; the bit being emitted this
  // cycle is already in vox_code, so the word is cleared one step ahead.
  prm_lsb_find u_lsb_find (
    .word  (scan_src),
    .idx   (bit_idx),
    .found (found)
  );

  always_comb begin
    state_nxt     = state;
    scan_src      = word;
    clear_all     = 1'b0;
    emit          = 1'b0;
    step          = 1'b0;
    addr_inc      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    bus.mem_rd_en = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          clear_all = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        busy          = 1'b1;
        bus.mem_rd_en = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        busy     = 1'b1;
        scan_src = bus.mem_rd_data;
        if (found) begin
          emit      = 1'b1;
          state_nxt = SCAN;
        end else begin
          step = 1'b1;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (found) emit = 1'b1;
        else       step = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (step) begin
      if (bus.mem_addr == ADDR_LAST) begin
        state_nxt = DONE;
      end else begin
        addr_inc  = 1'b1;
        state_nxt = FETCH;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process ordering cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_addr  <= '0;
      bus.vox_valid <= 1'b0;
      bus.vox_code  <= '0;
      word          <= '0;
      blocked       <= '0;
      vox_count     <= '0;
    end else begin
      if (clear_all) begin
        bus.mem_addr <= '0;
        blocked      <= '0;
        vox_count    <= '0;
      end else begin
        if (addr_inc) bus.mem_addr <= bus.mem_addr + 1'b1;
        if (bus.vox_valid) begin
          blocked <= blocked | bus.edge_mask_in;
          if (vox_count != 16'hFFFF) vox_count <= vox_count + 16'd1;
        end
      end

      bus.vox_valid <= emit;
      if (emit) begin
        bus.vox_code <= {bus.mem_addr, bit_idx};
        word         <= scan_src & ~(WORD_W'(1) << bit_idx);
      end
    end
  end

endmodule

// File: tb/tb_prm_voxel_feeder.sv
// Directed bench for prm_voxel_feeder: table of bitmap scenarios with
// hand-computed results, plus random-map, mid-scan start and mid-scan reset.
module tb_prm_voxel_feeder;
  import prm_vox_pkg::*;

  localparam int NE    = 16;
  localparam int LIMIT = 40000;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [NE-1:0]   blocked;
  logic [15:0]     vox_count;

  logic [31:0]     mem [1024];

  int checks = 0;
  int errors = 0;

  prm_voxel_feeder_if #(.NUM_EDGES(NE)) bus ();

  prm_voxel_feeder #(.NUM_EDGES(NE), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .blocked   (blocked),
    .vox_count (vox_count),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checker-bank stand-in: each code blocks edge (code + 2) mod 16.
  function automatic logic [NE-1:0] chk_mask(input logic [14:0] c);
    logic [3:0] b;
    b = 4'(c + 15'd2);
    return 16'h1 << b;
  endfunction

  assign bus.edge_mask_in = chk_mask(bus.vox_code);

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
  endtask

  // Starts a scan from a negedge in IDLE and observes it until done.
  // Cycle 1 is the start cycle; done_n is the cycle done is seen (-1 on timeout).
  task automatic run_scan(input bit inject, output int done_n, output int nvalid,
                          output int first, output int last, output int last_vn,
                          output int max_run, output int order_err,
                          output int busy2, output int busy_done, output int first_addr);
    int n, run, prev;
    done_n = -1; nvalid = 0; first = -1; last = -1; last_vn = 0;
    max_run = 0; order_err = 0; busy2 = -1; busy_done = -1; first_addr = -1;
    run = 0; prev = -1;
    start = 1'b1;
    n = 1;
    while (n < LIMIT) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      start = (inject && n == 500);
      if (n == 2) busy2 = int'(busy);
      if (bus.mem_rd_en && first_addr < 0) first_addr = int'(bus.mem_addr);
      if (bus.vox_valid) begin
        nvalid++;
        if (first < 0) first = int'(bus.vox_code);
        if (prev >= 0 && int'(bus.vox_code) <= prev) order_err++;
        prev    = int'(bus.vox_code);
        last    = prev;
        last_vn = n;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (done) begin
        done_n    = n;
        busy_done = int'(busy);
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    int          a0;
    logic [31:0] w0;
    int          a1;
    logic [31:0] w1;
    int          exp_done_n;
    int          exp_cnt;
    logic [15:0] exp_blk;
    int          exp_first;
    int          exp_last;
    int          exp_last_vn;
    int          exp_run;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int done_n, nvalid, first, last, last_vn, max_run, order_err;
    int busy2, busy_done, first_addr, p, pulses;
    logic [NE-1:0] blk_hold, exp_blk;
    logic [9:0] ra;
    logic [4:0] rb;

    vecs[0] = '{-1,   32'h0,        -1,  32'h0,        2050, 0,  16'h0000, -1,    -1,    0,    0};
    vecs[1] = '{3,    32'h0000_0020, -1,  32'h0,        2051, 1,  16'h0080, 101,   101,   10,   1};
    vecs[2] = '{0,    32'hFFFF_FFFF, -1,  32'h0,        2082, 32, 16'hFFFF, 0,     31,    35,   32};
    vecs[3] = '{1023, 32'h8000_0000, -1,  32'h0,        2051, 1,  16'h0002, 32767, 32767, 2050, 1};
    vecs[4] = '{5,    32'h0000_0101, 700, 32'h4000_0002, 2054, 4,  16'h040D, 160,   22430, 1407, 2};

    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy",      busy,          1'b0);
    check("rst done",      done,          1'b0);
    check("rst mem_rd_en", bus.mem_rd_en, 1'b0);
    check("rst mem_addr",  bus.mem_addr,  10'd0);
    check("rst vox_valid", bus.vox_valid, 1'b0);
    check("rst vox_code",  bus.vox_code,  15'd0);
    check("rst blocked",   blocked,       16'h0);
    check("rst vox_count", vox_count,     16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      clear_mem();
      if (vecs[v].a0 >= 0) mem[vecs[v].a0] = vecs[v].w0;
      if (vecs[v].a1 >= 0) mem[vecs[v].a1] = vecs[v].w1;
      run_scan(1'b0, done_n, nvalid, first, last, last_vn, max_run, order_err,
               busy2, busy_done, first_addr);
      check($sformatf("v%0d done cycle", v), done_n,    vecs[v].exp_done_n);
      check($sformatf("v%0d vox_count", v),  vox_count, vecs[v].exp_cnt);
      check($sformatf("v%0d valid cycles", v), nvalid,  vecs[v].exp_cnt);
      check($sformatf("v%0d blocked", v),    blocked,   vecs[v].exp_blk);
      check($sformatf("v%0d first code", v), first,     vecs[v].exp_first);
      check($sformatf("v%0d last code", v),  last,      vecs[v].exp_last);
      check($sformatf("v%0d last valid cycle", v), last_vn, vecs[v].exp_last_vn);
      check($sformatf("v%0d longest run", v), max_run,  vecs[v].exp_run);
      check($sformatf("v%0d order", v),      order_err, 0);
      check($sformatf("v%0d busy after start", v), busy2, 1);
      check($sformatf("v%0d busy at done", v), busy_done, 0);
      blk_hold = blocked;
      @(negedge clk);
      check($sformatf("v%0d done single pulse", v), done, 1'b0);
      check($sformatf("v%0d blocked holds", v), blocked, blk_hold);
    end

    // Random sparse map against a bit-by-bit model; a stray start mid-scan.
    clear_mem();
    for (int i = 0; i < 24; i++) begin
      ra = 10'($urandom_range(0, 1023));
      rb = 5'($urandom_range(0, 31));
      mem[ra][rb] = 1'b1;
    end
    p = 0;
    exp_blk = '0;
    for (int a = 0; a < 1024; a++) begin
      for (int b = 0; b < 32; b++) begin
        if (mem[a][b]) begin
          p++;
          exp_blk |= chk_mask({10'(a), 5'(b)});
        end
      end
    end
    run_scan(1'b1, done_n, nvalid, first, last, last_vn, max_run, order_err,
             busy2, busy_done, first_addr);
    check("rand done cycle",   done_n,    2050 + p);
    check("rand vox_count",    vox_count, p);
    check("rand valid cycles", nvalid,    p);
    check("rand blocked",      blocked,   exp_blk);
    check("rand order",        order_err, 0);
    @(negedge clk);

    // Reset during SCAN of word 5, then a clean rescan from address 0.
    clear_mem();
    mem[5] = 32'h0000_00F0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bus.vox_valid && bus.vox_code[14:5] == 10'd5) break;
      @(negedge clk);
    end
    check("mid reset reached word 5", bus.vox_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid rst busy",      busy,          1'b0);
    check("mid rst done",      done,          1'b0);
    check("mid rst mem_rd_en", bus.mem_rd_en, 1'b0);
    check("mid rst mem_addr",  bus.mem_addr,  10'd0);
    check("mid rst vox_valid", bus.vox_valid, 1'b0);
    check("mid rst vox_code",  bus.vox_code,  15'd0);
    check("mid rst blocked",   blocked,       16'h0);
    check("mid rst vox_count", vox_count,     16'd0);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 2100; n++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("no activity after reset", pulses, 0);
    run_scan(1'b0, done_n, nvalid, first, last, last_vn, max_run, order_err,
             busy2, busy_done, first_addr);
    check("rescan first addr", first_addr, 0);
    check("rescan done cycle", done_n,     2054);
    check("rescan vox_count",  vox_count,  4);
    check("rescan first code", first,      164);
    check("rescan blocked",    blocked,    16'h03C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
